// File: rtl/trng_postproc_pkg.sv
// Shared definitions for the TRNG post-processing slice.
//   PP_WIDTH       : default output word width
//   PP_RCT_CUTOFF  : default repetition-count cutoff
//   pair_state_t   : von Neumann pair phase (A = waiting for first bit,
//                    B = holding first bit, waiting for second)
package trng_postproc_pkg;
  localparam int PP_WIDTH      = 8;
  localparam int PP_RCT_CUTOFF = 32;

  typedef enum logic {
    PAIR_A = 1'b0,
    PAIR_B = 1'b1
  } pair_state_t;
endpackage

// File: rtl/vn_extractor.sv
// Von Neumann debiaser: consumes one sampled bit per enabled cycle, groups
// them into non-overlapping pairs and emits 0 for "01", 1 for "10", nothing
// for "00"/"11".
//   clock, reset_n : clock, async active-low reset
//   sample_en      : bit_in is a valid sample this cycle; 0 drops any half pair
//   bit_in         : sampled raw bit
//   flush          : hold the pair FSM in A and suppress emission
//   emit, emit_bit : one-cycle strobe and the debiased bit
module vn_extractor
  import trng_postproc_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic sample_en,
  input  logic bit_in,
  input  logic flush,
  output logic emit,
  output logic emit_bit
);

  pair_state_t state, state_nxt;
  logic        first_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= PAIR_A;
      first_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (sample_en && !flush && state == PAIR_A) first_q <= bit_in;
    end
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_bit  = 1'b0;
    if (flush || !sample_en) begin
      state_nxt = PAIR_A;
    end else begin
      case (state)
        PAIR_A: state_nxt = PAIR_B;
        PAIR_B: begin
          state_nxt = PAIR_A;
          // first bit of an unequal pair is the output bit (10 -> 1, 01 -> 0)
          emit      = (first_q != bit_in);
          emit_bit  = first_q;
        end
        default: state_nxt = PAIR_A;
      endcase
    end
  end

endmodule

// File: rtl/trng_postproc.sv
// TRNG post-processing: sync stage, von Neumann debias, WIDTH-bit packer with
// valid/ready output register, and a sticky repetition-count health test.
//   clock, reset_n        : clock, async active-low reset
//   raw_bit, enable       : raw RO bit and its sample enable
//   out_data, out_valid   : packed word and its valid flag
//   out_ready             : consumer accept; transfer when valid && ready
//   health_fail           : sticky repetition-count failure
//   clear_fail            : single-cycle clear of health_fail
module trng_postproc
  import trng_postproc_pkg::*;
#(
  parameter int WIDTH      = PP_WIDTH,
  parameter int RCT_CUTOFF = PP_RCT_CUTOFF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             raw_bit,
  input  logic             enable,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             health_fail,
  input  logic             clear_fail
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(RCT_CUTOFF + 1);

  // sync stage; smp_vld marks that sync_q holds a fresh sample to evaluate
  logic sync_q, smp_vld;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 1'b0;
      smp_vld <= 1'b0;
    end else begin
      smp_vld <= enable;
      if (enable) sync_q <= raw_bit;
    end
  end

  // repetition-count health test
  logic          prev_bit;
  logic [RW-1:0] run_cnt, run_nxt;
  logic          fail_set, fail_nxt;

  always_comb begin
    run_nxt  = run_cnt;
    fail_set = 1'b0;
    if (smp_vld) begin
      if (sync_q == prev_bit) begin
        if (run_cnt != RW'(RCT_CUTOFF)) run_nxt = run_cnt + 1'b1;
        // fire only on the transition into the cutoff, not while saturated
        fail_set = (run_cnt == RW'(RCT_CUTOFF - 1));
      end else begin
        run_nxt = RW'(1);
      end
    end
  end

  // a failure detected on the clear edge wins over the clear
  assign fail_nxt = fail_set | (health_fail & ~clear_fail);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_bit    <= 1'b0;
      run_cnt     <= RW'(1);
      health_fail <= 1'b0;
    end else begin
      if (smp_vld) prev_bit <= sync_q;
      run_cnt     <= clear_fail ? RW'(1) : run_nxt;
      health_fail <= fail_nxt;
    end
  end

  // debiaser
  logic emit, emit_bit;

  vn_extractor u_vn (
    .clock     (clock),
    .reset_n   (reset_n),
    .sample_en (smp_vld),
    .bit_in    (sync_q),
    .flush     (health_fail),
    .emit      (emit),
    .emit_bit  (emit_bit)
  );

  // packer + output register; count == WIDTH means a finished word waits
  // in acc for the output register to free up
  logic [WIDTH-1:0] acc, acc_shift;
  logic [CW-1:0]    count;
  logic             out_free, acc_full;

  assign acc_shift = {acc[WIDTH-2:0], emit_bit};
  assign out_free  = !out_valid || out_ready;
  assign acc_full  = (count == CW'(WIDTH));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (fail_nxt) begin
      // out_data kept as-is, but the word is no longer offered
      out_valid <= 1'b0;
      count     <= '0;
    end else if (acc_full) begin
      // emitted bits are dropped while a completed word is parked
      if (out_free) begin
        out_data  <= acc;
        out_valid <= 1'b1;
        count     <= '0;
      end
    end else if (emit && count == CW'(WIDTH - 1)) begin
      if (out_free) begin
        out_data  <= acc_shift;
        out_valid <= 1'b1;
        count     <= '0;
      end else begin
        acc   <= acc_shift;
        count <= CW'(WIDTH);
      end
    end else begin
      if (emit) begin
        acc   <= acc_shift;
        count <= count + 1'b1;
      end
      if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trng_postproc.sv
// Directed bench for trng_postproc (WIDTH=8, RCT_CUTOFF=32). Inputs change
// 1 time unit after each rising edge; outputs are checked at the same point.
module tb_trng_postproc;

  logic       clock;
  logic       reset_n;
  logic       raw_bit;
  logic       enable;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       health_fail;
  logic       clear_fail;

  int nvec = 0;
  int nerr = 0;

  trng_postproc #(.WIDTH(8), .RCT_CUTOFF(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .raw_bit     (raw_bit),
    .enable      (enable),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .health_fail (health_fail),
    .clear_fail  (clear_fail)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clock);
    #1;
  endtask

  task automatic feed(input logic b);
    raw_bit = b;
    enable  = 1'b1;
    clk1();
  endtask

  task automatic idle();
    enable = 1'b0;
    clk1();
  endtask

  // each word bit (MSB first) as a good pair: 1 -> "10", 0 -> "01"
  task automatic feed_pairs(input logic [7:0] w, input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = w[7-i];
      feed(b);
      feed(!b);
    end
  endtask

  task automatic feed_word(input logic [7:0] w);
    feed_pairs(w, 8);
    idle();
  endtask

  task automatic feed_run(input int n);
    feed(1'b0);
    for (int i = 0; i < n; i++) feed(1'b1);
  endtask

  initial begin
    logic [19:0] pm;
    reset_n = 1'b0; raw_bit = 1'b0; enable = 1'b0;
    out_ready = 1'b1; clear_fail = 1'b0;

    // reset state
    clk1();
    chk("rst_data",  32'(out_data),    32'h0);
    chk("rst_valid", 32'(out_valid),   32'h0);
    chk("rst_fail",  32'(health_fail), 32'h0);
    clk1();
    reset_n = 1'b1;

    // reset held mid-stream discards a partial word
    feed_pairs(8'hE0, 3);
    reset_n = 1'b0;
    feed(1'b1); feed(1'b0);
    chk("rst_mid_data",  32'(out_data),  32'h0);
    chk("rst_mid_valid", 32'(out_valid), 32'h0);
    reset_n = 1'b1;

    // pair mapping: 10,01,10,10,00,11,01,01,10,01 -> 8'hB2
    pm = 20'b10_01_10_10_00_11_01_01_10_01;
    for (int i = 19; i >= 0; i--) feed(pm[i]);
    chk("map_latency", 32'(out_valid), 32'h0);
    idle();
    chk("map_valid", 32'(out_valid), 32'h1);
    chk("map_data",  32'(out_data),  32'hB2);
    idle();
    chk("map_one_cycle", 32'(out_valid), 32'h0);

    // backpressure
    out_ready = 1'b0;
    feed_word(8'hA5);
    chk("bp_w0_valid", 32'(out_valid), 32'h1);
    chk("bp_w0_data",  32'(out_data),  32'hA5);
    feed_word(8'h3C);
    chk("bp_hold_data", 32'(out_data), 32'hA5);
    feed_word(8'hFF);
    chk("bp_drop_valid", 32'(out_valid), 32'h1);
    chk("bp_drop_data",  32'(out_data),  32'hA5);
    out_ready = 1'b1;
    idle();
    chk("bp_w1_valid", 32'(out_valid), 32'h1);
    chk("bp_w1_data",  32'(out_data),  32'h3C);
    idle();
    chk("bp_drain", 32'(out_valid), 32'h0);
    feed_word(8'h5A);
    chk("bp_next_data", 32'(out_data), 32'h5A);
    idle();
    chk("bp_next_drain", 32'(out_valid), 32'h0);

    // health: pending word is withdrawn when 32 identical bits arrive
    out_ready = 1'b0;
    feed_word(8'hC3);
    chk("hl_pend_data", 32'(out_data), 32'hC3);
    feed_run(32);
    chk("hl_31_fail",  32'(health_fail), 32'h0);
    chk("hl_31_valid", 32'(out_valid),   32'h1);
    idle();
    chk("hl_32_fail",  32'(health_fail), 32'h1);
    chk("hl_32_valid", 32'(out_valid),   32'h0);
    chk("hl_32_data",  32'(out_data),    32'hC3);
    clear_fail = 1'b1; clk1(); clear_fail = 1'b0;
    chk("hl_clear", 32'(health_fail), 32'h0);
    out_ready = 1'b1;
    feed_word(8'h96);
    chk("hl_after_valid", 32'(out_valid), 32'h1);
    chk("hl_after_data",  32'(out_data),  32'h96);
    idle();

    // clear coincident with a new failure: failure wins
    feed_run(32);
    idle();
    chk("hl2_fail", 32'(health_fail), 32'h1);
    feed_run(32);
    clear_fail = 1'b1; enable = 1'b0; clk1(); clear_fail = 1'b0;
    chk("hl2_coincident", 32'(health_fail), 32'h1);
    clear_fail = 1'b1; clk1(); clear_fail = 1'b0;
    chk("hl2_clear", 32'(health_fail), 32'h0);
    chk("hl2_valid", 32'(out_valid),   32'h0);

    // enable gap inside a pair drops the half pair
    feed_pairs(8'h60, 3);
    feed(1'b1);
    idle();
    feed_pairs(8'h68, 5);
    idle();
    chk("gap_valid", 32'(out_valid), 32'h1);
    chk("gap_data",  32'(out_data),  32'h6D);

    // reset after 5 emitted bits
    feed_pairs(8'hF8, 5);
    idle();
    reset_n = 1'b0; clk1(); reset_n = 1'b1;
    chk("rw_valid", 32'(out_valid), 32'h0);
    chk("rw_data",  32'(out_data),  32'h0);
    feed_pairs(8'h4E, 7);
    idle();
    chk("rw_partial", 32'(out_valid), 32'h0);
    feed_pairs(8'h00, 1);
    idle();
    chk("rw_valid2", 32'(out_valid), 32'h1);
    chk("rw_data2",  32'(out_data),  32'h4E);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
